// File: rtl/wb_stage_if.sv
// Bundle between the MEM stage / decode-stage register file and the write-back stage.
// The master side drives the MEM/WB capture inputs and the bypass query; the slave is wb_stage.
interface wb_stage_if #(
    parameter int CNTW = 32
);
    logic            Stall;
    logic            Flush;
    logic            Valid_In;
    logic            RegWrite_In;
    logic            MemToReg_In;
    logic            SignExt_In;
    logic [1:0]      ByteSel_In;
    logic [1:0]      RegDst_In;
    logic [4:0]      Rt_In;
    logic [4:0]      Rd_In;
    logic [31:0]     ALUResult_In;
    logic [31:0]     MemData_In;
    logic [31:0]     PCI_In;
    logic [4:0]      WriteAddr;
    logic [31:0]     WriteData;
    logic            RW_AND;
    logic [4:0]      BypassAddr;
    logic            BypassHit;
    logic            AlignErr;
    logic [CNTW-1:0] RetireCount;

    modport master (
        output Stall, Flush, Valid_In, RegWrite_In, MemToReg_In, SignExt_In,
               ByteSel_In, RegDst_In, Rt_In, Rd_In, ALUResult_In, MemData_In,
               PCI_In, BypassAddr,
        input  WriteAddr, WriteData, RW_AND, BypassHit, AlignErr, RetireCount
    );

    modport slave (
        input  Stall, Flush, Valid_In, RegWrite_In, MemToReg_In, SignExt_In,
               ByteSel_In, RegDst_In, Rt_In, Rd_In, ALUResult_In, MemData_In,
               PCI_In, BypassAddr,
        output WriteAddr, WriteData, RW_AND, BypassHit, AlignErr, RetireCount
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, result-source mux, sub-word load extraction,
// destination select, register-file write enable, decode-stage bypass and retire counter.
module wb_stage #(
    parameter int DW   = 32,
    parameter int CNTW = 32
) (
    input  logic       Clk,
    input  logic       Rst,
    wb_stage_if.slave  wb
);
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;

    logic            valid_q,    valid_d;
    logic            regwrite_q, regwrite_d;
    logic            memtoreg_q, memtoreg_d;
    logic            signext_q,  signext_d;
    logic [1:0]      bytesel_q,  bytesel_d;
    logic [1:0]      regdst_q,   regdst_d;
    logic [4:0]      rt_q,       rt_d;
    logic [4:0]      rd_q,       rd_d;
    logic [DW-1:0]   alu_q,      alu_d;
    logic [DW-1:0]   mem_q,      mem_d;
    logic [DW-1:0]   pci_q,      pci_d;
    logic [CNTW-1:0] count_q,    count_d;

    logic [4:0]      dest_s;
    logic [15:0]     half_s;
    logic [7:0]      byte_s;
    logic [DW-1:0]   load_s;
    logic [DW-1:0]   data_s;
    logic            misalign_s;
    logic            align_err_s;
    logic            rw_s;
    logic            hit_s;

    // Next pipeline-register contents: Flush beats Stall beats a normal load.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        memtoreg_d = memtoreg_q;
        signext_d  = signext_q;
        bytesel_d  = bytesel_q;
        regdst_d   = regdst_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        alu_d      = alu_q;
        mem_d      = mem_q;
        pci_d      = pci_q;
        count_d    = count_q;
        if (wb.Flush) begin
            valid_d = 1'b0;
        end else if (wb.Stall) begin
            valid_d = valid_q;
        end else begin
            valid_d    = wb.Valid_In;
            regwrite_d = wb.RegWrite_In;
            memtoreg_d = wb.MemToReg_In;
            signext_d  = wb.SignExt_In;
            bytesel_d  = wb.ByteSel_In;
            regdst_d   = wb.RegDst_In;
            rt_d       = wb.Rt_In;
            rd_d       = wb.Rd_In;
            alu_d      = wb.ALUResult_In;
            mem_d      = wb.MemData_In;
            pci_d      = wb.PCI_In;
            if (wb.Valid_In) begin
                count_d = count_q + {{(CNTW-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end
    end

    // MEM/WB register and retire counter, synchronously cleared.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            signext_q  <= 1'b0;
            bytesel_q  <= 2'b00;
            regdst_q   <= 2'b00;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            alu_q      <= {DW{1'b0}};
            mem_q      <= {DW{1'b0}};
            pci_q      <= {DW{1'b0}};
            count_q    <= {CNTW{1'b0}};
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            memtoreg_q <= memtoreg_d;
            signext_q  <= signext_d;
            bytesel_q  <= bytesel_d;
            regdst_q   <= regdst_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            alu_q      <= alu_d;
            mem_q      <= mem_d;
            pci_q      <= pci_d;
            count_q    <= count_d;
        end
    end

    // Write-port outputs derived from the held instruction; lanes are little-endian.
    always_comb begin
        case (regdst_q)
            DST_RD:   dest_s = rd_q;
            DST_LINK: dest_s = 5'd31;
            default:  dest_s = rt_q;
        endcase

        if (alu_q[1]) begin
            half_s = mem_q[31:16];
        end else begin
            half_s = mem_q[15:0];
        end

        case (alu_q[1:0])
            2'b00:   byte_s = mem_q[7:0];
            2'b01:   byte_s = mem_q[15:8];
            2'b10:   byte_s = mem_q[23:16];
            2'b11:   byte_s = mem_q[31:24];
            default: byte_s = mem_q[7:0];
        endcase

        case (bytesel_q)
            SEL_HALF: begin
                load_s     = {{(DW-16){signext_q & half_s[15]}}, half_s};
                misalign_s = alu_q[0];
            end
            SEL_BYTE: begin
                load_s     = {{(DW-8){signext_q & byte_s[7]}}, byte_s};
                misalign_s = 1'b0;
            end
            default: begin
                load_s     = mem_q;
                misalign_s = |alu_q[1:0];
            end
        endcase

        if (regdst_q == DST_LINK) begin
            data_s = pci_q;
        end else if (memtoreg_q) begin
            data_s = load_s;
        end else begin
            data_s = alu_q;
        end

        // The link path never touches memory, so it can never be misaligned.
        align_err_s = valid_q & memtoreg_q & (regdst_q != DST_LINK) & misalign_s;
        rw_s        = valid_q & regwrite_q & (dest_s != 5'd0) & ~align_err_s;
        hit_s       = rw_s & (dest_s == wb.BypassAddr);
    end

    assign wb.WriteAddr   = dest_s;
    assign wb.WriteData   = data_s;
    assign wb.RW_AND      = rw_s;
    assign wb.BypassHit   = hit_s;
    assign wb.AlignErr    = align_err_s;
    assign wb.RetireCount = count_q;
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed cases then random traffic against a rule-level reference model.
// A second instance with a 4-bit counter shares the stimulus so counter wrap is reachable.
module tb_wb_stage;
    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        signext;
        logic [1:0]  bytesel;
        logic [1:0]  regdst;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pci;
    } ins_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    wb_stage_if #(.CNTW(32)) bus ();
    wb_stage_if #(.CNTW(4))  bus4 ();

    wb_stage #(.DW(32), .CNTW(32)) u_dut   (.Clk(clk), .Rst(rst), .wb(bus));
    wb_stage #(.DW(32), .CNTW(4))  u_dut4  (.Clk(clk), .Rst(rst), .wb(bus4));

    assign bus4.Stall        = bus.Stall;
    assign bus4.Flush        = bus.Flush;
    assign bus4.Valid_In     = bus.Valid_In;
    assign bus4.RegWrite_In  = bus.RegWrite_In;
    assign bus4.MemToReg_In  = bus.MemToReg_In;
    assign bus4.SignExt_In   = bus.SignExt_In;
    assign bus4.ByteSel_In   = bus.ByteSel_In;
    assign bus4.RegDst_In    = bus.RegDst_In;
    assign bus4.Rt_In        = bus.Rt_In;
    assign bus4.Rd_In        = bus.Rd_In;
    assign bus4.ALUResult_In = bus.ALUResult_In;
    assign bus4.MemData_In   = bus.MemData_In;
    assign bus4.PCI_In       = bus.PCI_In;
    assign bus4.BypassAddr   = bus.BypassAddr;

    always #5 clk = ~clk;

    ins_t        pend_ins;
    logic        pend_stall, pend_flush, pend_rst;
    ins_t        held;
    logic [31:0] exp_cnt;

    function automatic logic [4:0] ref_dest(ins_t i);
        if (i.regdst == 2'd1) return i.rd;
        if (i.regdst == 2'd2) return 5'd31;
        return i.rt;
    endfunction

    function automatic logic [31:0] ref_data(ins_t i);
        logic [31:0] v;
        if (i.regdst == 2'd2) return i.pci;
        if (!i.memtoreg) return i.alu;
        if (i.bytesel == 2'd1) begin
            v = (i.mem >> (16 * i.alu[1])) & 32'h0000FFFF;
            if (i.signext && v >= 32'h00008000) v = v - 32'h00010000;
            return v;
        end
        if (i.bytesel == 2'd2) begin
            v = (i.mem >> (8 * i.alu[1:0])) & 32'h000000FF;
            if (i.signext && v >= 32'h00000080) v = v - 32'h00000100;
            return v;
        end
        return i.mem;
    endfunction

    function automatic logic ref_align(ins_t i);
        logic is_word;
        is_word = (i.bytesel == 2'd0) || (i.bytesel == 2'd3);
        return i.valid && i.memtoreg && (i.regdst != 2'd2) &&
               (((i.bytesel == 2'd1) && (i.alu % 2 == 1)) || (is_word && (i.alu % 4 != 0)));
    endfunction

    function automatic logic ref_rw(ins_t i);
        return i.valid && i.regwrite && (ref_dest(i) != 5'd0) && !ref_align(i);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic drive(input ins_t i, input logic st, input logic fl, input logic r);
        bus.Valid_In     = i.valid;
        bus.RegWrite_In  = i.regwrite;
        bus.MemToReg_In  = i.memtoreg;
        bus.SignExt_In   = i.signext;
        bus.ByteSel_In   = i.bytesel;
        bus.RegDst_In    = i.regdst;
        bus.Rt_In        = i.rt;
        bus.Rd_In        = i.rd;
        bus.ALUResult_In = i.alu;
        bus.MemData_In   = i.mem;
        bus.PCI_In       = i.pci;
        bus.Stall        = st;
        bus.Flush        = fl;
        rst              = r;
        pend_ins = i; pend_stall = st; pend_flush = fl; pend_rst = r;
    endtask

    // One clock edge, with the reference model applying the priority rules to what was driven.
    task automatic tick();
        @(posedge clk);
        if (pend_rst) begin
            held = '0; exp_cnt = 32'd0;
        end else if (pend_flush) begin
            held.valid = 1'b0;
        end else if (!pend_stall) begin
            held = pend_ins;
            if (pend_ins.valid) exp_cnt = exp_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic check_model(input string tag, input logic [4:0] byp);
        logic rw;
        bus.BypassAddr = byp;
        #1;
        rw = ref_rw(held);
        chk({tag, ".rw"},    {31'd0, bus.RW_AND},    {31'd0, rw});
        chk({tag, ".align"}, {31'd0, bus.AlignErr},  {31'd0, ref_align(held)});
        chk({tag, ".hit"},   {31'd0, bus.BypassHit}, {31'd0, rw && (ref_dest(held) == byp)});
        chk({tag, ".cnt"},   bus.RetireCount, exp_cnt);
        chk({tag, ".cnt4"},  {28'd0, bus4.RetireCount}, exp_cnt % 32'd16);
        if (held.valid) chk({tag, ".addr"}, {27'd0, bus.WriteAddr}, {27'd0, ref_dest(held)});
        if (rw)         chk({tag, ".data"}, bus.WriteData, ref_data(held));
    endtask

    function automatic ins_t mk(input logic [1:0] bsel, input logic [1:0] rdst, input logic m2r,
                                input logic se, input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pci);
        ins_t i;
        i.valid = 1'b1; i.regwrite = 1'b1; i.memtoreg = m2r; i.signext = se;
        i.bytesel = bsel; i.regdst = rdst; i.rt = rt; i.rd = rd;
        i.alu = alu; i.mem = mem; i.pci = pci;
        return i;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        i.valid    = ($urandom_range(0, 3) != 0);
        i.regwrite = ($urandom_range(0, 4) != 0);
        i.memtoreg = $urandom_range(0, 1) == 1;
        i.signext  = $urandom_range(0, 1) == 1;
        i.bytesel  = 2'($urandom_range(0, 3));
        i.regdst   = 2'($urandom_range(0, 3));
        i.rt       = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31));
        i.rd       = 5'($urandom_range(0, 31));
        i.alu      = $urandom;
        i.mem      = $urandom;
        i.pci      = $urandom;
        return i;
    endfunction

    initial begin
        ins_t idle;
        ins_t i;
        logic st, fl, r;
        int   guard;
        idle = '0;
        held = '0;
        exp_cnt = 32'd0;
        bus.BypassAddr = 5'd0;

        // Reset then idle.
        drive(idle, 1'b0, 1'b0, 1'b1); tick();
        chk("rst.rw",   {31'd0, bus.RW_AND}, 32'd0);
        chk("rst.addr", {27'd0, bus.WriteAddr}, 32'd0);
        chk("rst.data", bus.WriteData, 32'd0);
        chk("rst.cnt",  bus.RetireCount, 32'd0);
        drive(idle, 1'b0, 1'b0, 1'b0); tick();
        check_model("idle", 5'd0);

        // ALU op into rd.
        drive(mk(2'd0, 2'd1, 1'b0, 1'b0, 5'd9, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        chk("alu.addr", {27'd0, bus.WriteAddr}, 32'd5);
        chk("alu.data", bus.WriteData, 32'hDEADBEEF);
        chk("alu.rw",   {31'd0, bus.RW_AND}, 32'd1);
        chk("alu.cnt",  bus.RetireCount, 32'd1);
        check_model("alu", 5'd5);

        // Sub-word loads.
        drive(mk(2'd2, 2'd0, 1'b1, 1'b1, 5'd7, 5'd0, 32'h3, 32'h80FF7F01, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        chk("lb.data", bus.WriteData, 32'hFFFFFF80);
        check_model("lb", 5'd7);
        drive(mk(2'd2, 2'd0, 1'b1, 1'b0, 5'd7, 5'd0, 32'h3, 32'h80FF7F01, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        chk("lbu.data", bus.WriteData, 32'h00000080);
        check_model("lbu", 5'd3);
        drive(mk(2'd1, 2'd0, 1'b1, 1'b1, 5'd8, 5'd0, 32'h2, 32'h80FF7F01, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        chk("lh.data", bus.WriteData, 32'hFFFF80FF);
        check_model("lh", 5'd8);

        // Misaligned half, then a write to r0.
        drive(mk(2'd1, 2'd0, 1'b1, 1'b1, 5'd8, 5'd0, 32'h1, 32'h80FF7F01, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        chk("mis.align", {31'd0, bus.AlignErr}, 32'd1);
        chk("mis.rw",    {31'd0, bus.RW_AND}, 32'd0);
        drive(mk(2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd4, 32'h1234, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        bus.BypassAddr = 5'd0; #1;
        chk("r0.rw",  {31'd0, bus.RW_AND}, 32'd0);
        chk("r0.hit", {31'd0, bus.BypassHit}, 32'd0);

        // Link write and bypass.
        drive(mk(2'd2, 2'd2, 1'b1, 1'b1, 5'd3, 5'd4, 32'h1, 32'h0, 32'h00400010), 1'b0, 1'b0, 1'b0); tick();
        bus.BypassAddr = 5'd31; #1;
        chk("jal.addr", {27'd0, bus.WriteAddr}, 32'd31);
        chk("jal.data", bus.WriteData, 32'h00400010);
        chk("jal.hit",  {31'd0, bus.BypassHit}, 32'd1);

        // Stall three cycles with different inputs presented.
        for (int k = 0; k < 3; k++) begin
            drive(rand_ins(), 1'b1, 1'b0, 1'b0); tick();
            chk("stall.data", bus.WriteData, 32'h00400010);
            check_model("stall", 5'd31);
        end
        chk("stall.cnt", bus.RetireCount, 32'd7);

        // Flush together with stall loads a bubble.
        drive(mk(2'd0, 2'd1, 1'b0, 1'b0, 5'd1, 5'd6, 32'h55, 32'h0, 32'h0), 1'b1, 1'b1, 1'b0); tick();
        chk("flush.rw", {31'd0, bus.RW_AND}, 32'd0);
        check_model("flush", 5'd6);

        // Reset while stalled.
        drive(mk(2'd0, 2'd1, 1'b0, 1'b0, 5'd1, 5'd6, 32'h55, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        drive(idle, 1'b1, 1'b0, 1'b1); tick();
        chk("rststall.rw",  {31'd0, bus.RW_AND}, 32'd0);
        chk("rststall.cnt", bus.RetireCount, 32'd0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            i  = rand_ins();
            st = ($urandom_range(0, 7) == 0);
            fl = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 99) == 0);
            drive(i, st, fl, r); tick();
            check_model("rand", ($urandom_range(0, 1) == 1) ? ref_dest(held) : 5'($urandom_range(0, 31)));
        end

        // Bring the 4-bit counter to its all-ones value, then one more valid load wraps it.
        guard = 0;
        while ((exp_cnt % 32'd16) != 32'd15 && guard < 40) begin
            drive(mk(2'd0, 2'd1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0); tick();
            guard++;
        end
        chk("wrap.pre", {28'd0, bus4.RetireCount}, 32'd15);
        drive(mk(2'd0, 2'd1, 1'b0, 1'b0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0, 1'b0); tick();
        chk("wrap.zero", {28'd0, bus4.RetireCount}, 32'd0);
        check_model("wrap", 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
